// File: rtl/uart_rx_word_arbiter_if.sv
// Bundle between the UART RX word arbiter, the RX byte FIFO and its two requesters.
// The slave modport is the arbiter's view; the master modport drives FIFO and requester inputs.
// The signal names match the arbiter's external port names so the wiring reads one-to-one.
interface uart_rx_word_arbiter_if;
  // FIFO read side
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  // Ownership switch
  logic        loader_done;
  // Loader port (words only)
  logic        ldr_req;
  logic        ldr_ack;
  logic [31:0] ldr_data;
  // Core port (byte or word)
  logic        core_req;
  logic        core_word;
  logic        core_ack;
  logic [31:0] core_data;
  // Status
  logic        busy;
  logic [31:0] rx_byte_count;
  logic        err_spurious;

  modport slave (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_valid,
    input  fifo_empty,
    input  loader_done,
    input  ldr_req,
    output ldr_ack,
    output ldr_data,
    input  core_req,
    input  core_word,
    output core_ack,
    output core_data,
    output busy,
    output rx_byte_count,
    output err_spurious
  );

  modport master (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_valid,
    output fifo_empty,
    output loader_done,
    output ldr_req,
    input  ldr_ack,
    input  ldr_data,
    output core_req,
    output core_word,
    input  core_ack,
    input  core_data,
    input  busy,
    input  rx_byte_count,
    input  err_spurious
  );
endinterface

// File: rtl/uart_rx_word_arbiter.sv
// Sole reader of the UART RX byte FIFO; assembles popped bytes little-endian and serves loader or core.
// Latency: grant + 3 cycles per byte + 1 to the one-cycle ack (word of 4 bytes: 13 cycles after grant).
// Backpressure: one outstanding pop at a time; stalls in ISSUE while the FIFO is empty, no timeout in WAIT.
module uart_rx_word_arbiter #(
  parameter int WORD_BYTES = 4
) (
  input logic                 clk,
  input logic                 rstn,
  uart_rx_word_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  typedef enum logic {
    OWN_LDR  = 1'b0,
    OWN_CORE = 1'b1
  } owner_t;

  localparam logic [2:0] WB = 3'(WORD_BYTES);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  target_q, target_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        rd_en_q, rd_en_d;
  logic        ldr_ack_q, ldr_ack_d;
  logic        core_ack_q, core_ack_d;
  logic [31:0] ldr_data_q, ldr_data_d;
  logic [31:0] core_data_q, core_data_d;
  logic        busy_q, busy_d;
  logic [31:0] rx_byte_count_q, rx_byte_count_d;
  logic        err_spurious_q, err_spurious_d;

  // Next-state and registered-output computation; the grant is taken only in IDLE and then held.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    target_d        = target_q;
    cnt_d           = cnt_q;
    asm_d           = asm_q;
    rd_en_d         = 1'b0;
    ldr_ack_d       = 1'b0;
    core_ack_d      = 1'b0;
    ldr_data_d      = ldr_data_q;
    core_data_d     = core_data_q;
    rx_byte_count_d = rx_byte_count_q;
    // A byte arriving when no pop is outstanding is dropped and flagged forever.
    err_spurious_d  = err_spurious_q | (bus.fifo_valid && (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE: begin
        // Only the port that owns the FIFO under the current loader_done can be granted.
        if (bus.ldr_req && !bus.loader_done) begin
          owner_d  = OWN_LDR;
          target_d = WB;
          state_d  = ST_ISSUE;
        end else if (bus.core_req && bus.loader_done) begin
          owner_d  = OWN_CORE;
          target_d = bus.core_word ? WB : 3'd1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.fifo_valid) begin
          asm_d[{cnt_q[1:0], 3'b000} +: 8] = bus.fifo_dout;
          cnt_d           = cnt_q + 3'd1;
          rx_byte_count_d = rx_byte_count_q + 32'd1;
          if ((cnt_q + 3'd1) == target_q) begin
            // Ack and data are registered so they appear together during DELIVER.
            state_d = ST_DELIVER;
            if (owner_q == OWN_LDR) begin
              ldr_ack_d  = 1'b1;
              ldr_data_d = asm_d;
            end else begin
              core_ack_d  = 1'b1;
              core_data_d = asm_d;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DELIVER: begin
        cnt_d   = 3'd0;
        asm_d   = 32'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction and drops the pop strobe at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_LDR;
      target_q        <= 3'd0;
      cnt_q           <= 3'd0;
      asm_q           <= 32'd0;
      rd_en_q         <= 1'b0;
      ldr_ack_q       <= 1'b0;
      core_ack_q      <= 1'b0;
      ldr_data_q      <= 32'd0;
      core_data_q     <= 32'd0;
      busy_q          <= 1'b0;
      rx_byte_count_q <= 32'd0;
      err_spurious_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      target_q        <= target_d;
      cnt_q           <= cnt_d;
      asm_q           <= asm_d;
      rd_en_q         <= rd_en_d;
      ldr_ack_q       <= ldr_ack_d;
      core_ack_q      <= core_ack_d;
      ldr_data_q      <= ldr_data_d;
      core_data_q     <= core_data_d;
      busy_q          <= busy_d;
      rx_byte_count_q <= rx_byte_count_d;
      err_spurious_q  <= err_spurious_d;
    end
  end

  assign bus.fifo_rd_en    = rd_en_q;
  assign bus.ldr_ack       = ldr_ack_q;
  assign bus.ldr_data      = ldr_data_q;
  assign bus.core_ack      = core_ack_q;
  assign bus.core_data     = core_data_q;
  assign bus.busy          = busy_q;
  assign bus.rx_byte_count = rx_byte_count_q;
  assign bus.err_spurious  = err_spurious_q;

endmodule

// File: tb/tb_uart_rx_word_arbiter.sv
// Directed bench for the UART RX word arbiter with a behavioural RX byte FIFO.
// Table of single-transaction vectors plus hand-written stall, handover, reset and error sequences.
module tb_uart_rx_word_arbiter;

  logic clk;
  logic rstn;

  uart_rx_word_arbiter_if bus ();

  uart_rx_word_arbiter #(.WORD_BYTES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: pop accepted on a clock edge, data valid for one cycle after it.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic       mdl_vld;
  logic [7:0] mdl_dat;
  logic       inj_vld;
  logic [7:0] inj_dat;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= wr_ptr;
      mdl_vld <= 1'b0;
      mdl_dat <= 8'd0;
    end else begin
      mdl_vld <= 1'b0;
      if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
        mdl_dat <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 8'd1;
        mdl_vld <= 1'b1;
      end
    end
  end

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_valid = mdl_vld | inj_vld;
  assign bus.fifo_dout  = inj_vld ? inj_dat : mdl_dat;

  int n_chk;
  int n_pass;
  logic [31:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic push_bytes(input int n, input logic [31:0] bytes);
    logic [31:0] b;
    b = bytes;
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr] = b[8*k +: 8];
      wr_ptr      = wr_ptr + 8'd1;
    end
  endtask

  // Runs for a fixed budget of cycles, counting pops and acks; a requester drops req on its ack.
  task automatic run_cycles(input int budget, input bit stop_on_ack,
                            output int nl, output int nc, output int pops,
                            output logic [31:0] ld, output logic [31:0] cd, output int lat);
    nl = 0; nc = 0; pops = 0; ld = 32'd0; cd = 32'd0; lat = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) pops++;
      if (bus.ldr_ack) begin
        nl++; ld = bus.ldr_data; lat = cyc; bus.ldr_req = 1'b0;
      end
      if (bus.core_ack) begin
        nc++; cd = bus.core_data; lat = cyc; bus.core_req = 1'b0;
      end
      if (stop_on_ack && (nl + nc) > 0) break;
    end
  endtask

  typedef struct {
    string       name;
    logic        loader_done;
    logic        ldr_req;
    logic        core_req;
    logic        core_word;
    int          nbytes;
    logic [31:0] bytes;
    int          exp_ldr_acks;
    int          exp_core_acks;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  int nl, nc, pops, lat;
  logic [31:0] ld, cd;

  initial begin
    n_chk = 0; n_pass = 0; exp_count = 32'd0;
    wr_ptr = 8'd0; inj_vld = 1'b0; inj_dat = 8'd0;
    bus.loader_done = 1'b0; bus.ldr_req = 1'b0; bus.core_req = 1'b0; bus.core_word = 1'b0;

    vecs[0] = '{"ldr_word",       1'b0, 1'b1, 1'b0, 1'b0, 4, 32'h12345678, 1, 0, 32'h12345678, 13};
    vecs[1] = '{"core_ignored",   1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0,        0, 0, 32'h0,         0};
    vecs[2] = '{"both_ldr_wins",  1'b0, 1'b1, 1'b1, 1'b1, 4, 32'hCAFEBABE, 1, 0, 32'hCAFEBABE, 13};
    vecs[3] = '{"core_byte",      1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h000000A5, 0, 1, 32'h000000A5,  4};
    vecs[4] = '{"both_core_wins", 1'b1, 1'b1, 1'b1, 1'b1, 4, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 13};
    vecs[5] = '{"ldr_ignored",    1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0,        0, 0, 32'h0,         0};

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_acks", {30'd0, bus.ldr_ack, bus.core_ack}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_count", bus.rx_byte_count, 32'd0);
    chk("rst_err", {31'd0, bus.err_spurious}, 32'd0);
    chk("rst_data", bus.ldr_data | bus.core_data, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      push_bytes(vecs[i].nbytes, vecs[i].bytes);
      bus.loader_done = vecs[i].loader_done;
      bus.ldr_req     = vecs[i].ldr_req;
      bus.core_req    = vecs[i].core_req;
      bus.core_word   = vecs[i].core_word;
      run_cycles(40, 1'b0, nl, nc, pops, ld, cd, lat);
      bus.ldr_req = 1'b0; bus.core_req = 1'b0;
      exp_count = exp_count + 32'(vecs[i].nbytes);
      chk({vecs[i].name, "_ldr_acks"}, 32'(nl), 32'(vecs[i].exp_ldr_acks));
      chk({vecs[i].name, "_core_acks"}, 32'(nc), 32'(vecs[i].exp_core_acks));
      chk({vecs[i].name, "_pops"}, 32'(pops), 32'(vecs[i].nbytes));
      chk({vecs[i].name, "_count"}, bus.rx_byte_count, exp_count);
      chk({vecs[i].name, "_busy"}, {31'd0, bus.busy}, 32'd0);
      if (vecs[i].exp_ldr_acks + vecs[i].exp_core_acks > 0) begin
        chk({vecs[i].name, "_data"}, (vecs[i].exp_ldr_acks > 0) ? ld : cd, vecs[i].exp_data);
        chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      end
    end
    // Output data holds its last delivered value between acks
    chk("ldr_data_hold", bus.ldr_data, 32'hCAFEBABE);
    chk("core_data_hold", bus.core_data, 32'hDEADBEEF);

    // Empty stall: no pop and no ack while the FIFO is empty, then completion
    @(negedge clk);
    bus.loader_done = 1'b0;
    bus.ldr_req     = 1'b1;
    run_cycles(50, 1'b0, nl, nc, pops, ld, cd, lat);
    chk("stall_pops", 32'(pops), 32'd0);
    chk("stall_acks", 32'(nl + nc), 32'd0);
    chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    push_bytes(4, 32'h04030201);
    run_cycles(40, 1'b1, nl, nc, pops, ld, cd, lat);
    exp_count = exp_count + 32'd4;
    chk("stall_ack", 32'(nl), 32'd1);
    chk("stall_data", ld, 32'h04030201);
    chk("stall_count", bus.rx_byte_count, exp_count);

    // Handover: core request ignored until loader_done rises
    @(negedge clk);
    bus.core_req  = 1'b1;
    bus.core_word = 1'b0;
    push_bytes(1, 32'h0000005A);
    run_cycles(20, 1'b0, nl, nc, pops, ld, cd, lat);
    chk("handover_wait_acks", 32'(nl + nc), 32'd0);
    chk("handover_wait_pops", 32'(pops), 32'd0);
    bus.loader_done = 1'b1;
    run_cycles(20, 1'b1, nl, nc, pops, ld, cd, lat);
    exp_count = exp_count + 32'd1;
    chk("handover_core_ack", 32'(nc), 32'd1);
    chk("handover_data", cd, 32'h0000005A);

    // Reset after two of four bytes: partial word is lost
    @(negedge clk);
    bus.loader_done = 1'b0;
    push_bytes(4, 32'h44332211);
    bus.ldr_req = 1'b1;
    run_cycles(8, 1'b0, nl, nc, pops, ld, cd, lat);
    chk("midrst_partial_count", bus.rx_byte_count, exp_count + 32'd2);
    chk("midrst_rd_en_before", {31'd0, bus.fifo_rd_en}, 32'd1);
    rstn = 1'b0;
    bus.ldr_req = 1'b0;
    #1;
    chk("midrst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_count", bus.rx_byte_count, 32'd0);
    chk("midrst_data", bus.ldr_data | bus.core_data, 32'd0);
    run_cycles(2, 1'b0, nl, nc, pops, ld, cd, lat);
    chk("midrst_no_ack", 32'(nl + nc), 32'd0);
    rstn = 1'b1;
    exp_count = 32'd0;
    @(negedge clk);
    push_bytes(4, 32'hAABBCCDD);
    bus.ldr_req = 1'b1;
    run_cycles(40, 1'b1, nl, nc, pops, ld, cd, lat);
    exp_count = 32'd4;
    chk("postrst_ack", 32'(nl), 32'd1);
    chk("postrst_data", ld, 32'hAABBCCDD);
    chk("postrst_count", bus.rx_byte_count, exp_count);

    // Spurious valid in IDLE, then byte counter wrap
    @(negedge clk);
    inj_dat = 8'h99;
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    chk("spur_err", {31'd0, bus.err_spurious}, 32'd1);
    chk("spur_count", bus.rx_byte_count, exp_count);
    chk("spur_no_ack", {30'd0, bus.ldr_ack, bus.core_ack}, 32'd0);
    dut.rx_byte_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.loader_done = 1'b1;
    bus.core_req    = 1'b1;
    bus.core_word   = 1'b0;
    push_bytes(1, 32'h00000042);
    run_cycles(20, 1'b1, nl, nc, pops, ld, cd, lat);
    chk("wrap_core_ack", 32'(nc), 32'd1);
    chk("wrap_data", cd, 32'h00000042);
    chk("wrap_count", bus.rx_byte_count, 32'd0);
    chk("wrap_err_sticky", {31'd0, bus.err_spurious}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
